// File: rtl/dmem_defs_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings and
// word geometry. Used by dmem_responder and dmem_array.
package dmem_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_BITS  = $clog2(WORD_BYTES);

  // A byte address is word aligned when its in-word offset bits are zero.
  function automatic logic is_aligned(input logic [BYTE_BITS-1:0] offset);
    return (offset == '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage for the data-memory responder: synchronous write,
// asynchronous (combinational) read. Contents are not cleared by reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Commit one word on the clock edge when write enable is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. One request is
// accepted in IDLE, held for LATENCY BUSY cycles (pipeline stalled), then
// completed in DONE where a store commits and a load returns its data.
// Optional build macro: DMEM_MISALIGN_CHECK_EN adds misalign_err and
// suppresses commits / returns zero for accesses with addr[1:0] != 0.
module dmem_responder
  import dmem_defs_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req_addr,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        stall
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t        state_reg;
  logic [3:0]    count_reg;
  logic [AW-1:0] idx_reg;
  logic [31:0]   wdata_reg;
  logic          is_write_reg;
  logic          is_read_reg;
  logic          misalign_reg;

  logic          req_any;
  logic          req_misalign;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  // Address bits above the word index wrap; offset bits only matter with the check enabled.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+BYTE_BITS], req_addr[BYTE_BITS-1:0]};

  assign req_any = req_read | req_write;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign req_misalign = ~is_aligned(req_addr[BYTE_BITS-1:0]);
`else
  assign req_misalign = 1'b0;
`endif

  // Stores land at the edge that closes DONE; misaligned stores are dropped.
  assign mem_we = (state_reg == ST_DONE) & is_write_reg & ~misalign_reg;

  // Hold the pipeline from the accepting cycle through the last BUSY cycle.
  assign stall = ~reset & (((state_reg == ST_IDLE) & req_any) | (state_reg == ST_BUSY));

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(idx_reg),
    .wdata(wdata_reg),
    .raddr(idx_reg),
    .rdata(mem_rdata)
  );

  // Request FSM: capture in IDLE, count down in BUSY, complete in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      is_write_reg <= 1'b0;
      is_read_reg  <= 1'b0;
      misalign_reg <= 1'b0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      rdata_valid <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (req_any) begin
            idx_reg      <= req_addr[AW+BYTE_BITS-1:BYTE_BITS];
            wdata_reg    <= req_wdata;
            is_write_reg <= req_write;
            // A simultaneous read and write is treated as a store only.
            is_read_reg  <= req_read & ~req_write;
            misalign_reg <= req_misalign;
            count_reg    <= CNT_INIT;
            state_reg    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (count_reg == 4'd0) begin
            state_reg <= ST_DONE;
            // Outputs are registered so they are valid throughout the DONE cycle.
            if (is_read_reg) begin
              rdata_valid <= 1'b1;
              rdata       <= misalign_reg ? 32'd0 : mem_rdata;
            end
`ifdef DMEM_MISALIGN_CHECK_EN
            misalign_err <= misalign_reg;
`endif
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end
        ST_DONE: begin
          // Never re-accept here, so a request still held is not replayed.
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2).
// A word-array model plus the access timing rule (stall for LATENCY+1
// cycles, completion in the following cycle) predicts every output.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk;
  logic        reset;
  logic [31:0] req_addr;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        stall;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_addr    (req_addr),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .stall       (stall)
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_model [DEPTH];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full access; the request stays asserted through DONE (must not replay).
  task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input string tag);
    int          idx;
    logic        mis;
    logic        is_load;
    logic [31:0] exp_data;
    idx = int'(a / 4) % DEPTH;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = (a % 4) != 0;
`else
    mis = 1'b0;
`endif
    is_load  = rd && !wr;
    exp_data = is_load ? (mis ? 32'd0 : mem_model[idx]) : last_rdata;

    @(posedge clk);
    #1;
    req_addr  = a;
    req_read  = rd;
    req_write = wr;
    req_wdata = wd;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      check({tag, "_stall"}, {31'd0, stall}, {31'd0, (k <= LAT)});
      check({tag, "_valid"}, {31'd0, rdata_valid}, {31'd0, (k == LAT + 1) && is_load});
`ifdef DMEM_MISALIGN_CHECK_EN
      check({tag, "_mis"}, {31'd0, misalign_err}, {31'd0, (k == LAT + 1) && mis});
`endif
      if (k == LAT + 1) check({tag, "_rdata"}, rdata, exp_data);
    end
    if (wr && !mis) mem_model[idx] = wd;
    if (is_load) last_rdata = exp_data;
    $display("txn %s addr=%h rd=%0d wr=%0d wdata=%h rdata=%h", tag, a, rd, wr, wd, rdata);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk);
    #1;
    req_read  = 1'b0;
    req_write = 1'b0;
    @(negedge clk);
    check({tag, "_idle_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_idle_valid"}, {31'd0, rdata_valid}, 32'd0);
    check({tag, "_idle_hold"}, rdata, last_rdata);
  endtask

  initial begin
    reset     = 1'b1;
    req_addr  = 32'h10;
    req_read  = 1'b1;
    req_write = 1'b0;
    req_wdata = 32'd0;
    last_rdata = 32'd0;

    // Reset state, with a request present: stall must be forced low.
    repeat (2) @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_valid", {31'd0, rdata_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("rst_mis", {31'd0, misalign_err}, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset    = 1'b0;
    req_read = 1'b0;

    // Preload every word so all later loads have known contents.
    for (int i = 0; i < DEPTH; i++) begin
      access(32'(i * 4), 1'b0, 1'b1, $urandom, "fill");
    end

    // Store then load, and back-to-back loads.
    access(32'h10, 1'b0, 1'b1, 32'hDEADBEEF, "st10");
    access(32'h10, 1'b1, 1'b0, 32'd0, "ld10");
    access(32'h14, 1'b1, 1'b0, 32'd0, "ld14");
    access(32'h10, 1'b1, 1'b0, 32'd0, "ld10b");
    idle_cycle("after_ld");

    // Read+write together behaves as a store.
    access(32'h20, 1'b1, 1'b1, 32'h1234, "rw20");
    access(32'h20, 1'b1, 1'b0, 32'd0, "ld20");

    // Reset during BUSY aborts a pending store.
    access(32'h30, 1'b0, 1'b1, 32'h11112222, "st30");
    @(posedge clk);
    #1;
    req_addr  = 32'h30;
    req_write = 1'b1;
    req_read  = 1'b0;
    req_wdata = 32'hAAAA5555;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_valid", {31'd0, rdata_valid}, 32'd0);
    req_write  = 1'b0;
    last_rdata = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    access(32'h30, 1'b1, 1'b0, 32'd0, "ld30");

    // Address wrap modulo depth.
    access(32'h400, 1'b0, 1'b1, 32'hCAFEF00D, "st400");
    access(32'h000, 1'b1, 1'b0, 32'd0, "ld000");

`ifdef DMEM_MISALIGN_CHECK_EN
    access(32'h42, 1'b0, 1'b1, 32'h55555555, "st42mis");
    access(32'h40, 1'b1, 1'b0, 32'd0, "ld40");
    access(32'h43, 1'b1, 1'b0, 32'd0, "ld43mis");
`endif

    // Randomized mix of loads, stores, read+write and idle cycles.
    for (int n = 0; n < 300; n++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      a  = $urandom;
`ifdef DMEM_MISALIGN_CHECK_EN
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
`endif
      if (op < 5)      access(a, 1'b1, 1'b0, 32'd0, "rnd_ld");
      else if (op < 8) access(a, 1'b0, 1'b1, $urandom, "rnd_st");
      else if (op < 9) access(a, 1'b1, 1'b1, $urandom, "rnd_rw");
      else             idle_cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
